// File: rtl/pc_pkg.sv
// Shared constants for the PC update stage: FSM state encoding, PC step and default reset PC.
package pc_pkg;

    localparam int          ADDR_W_DEFAULT   = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hFFFF_FFFC;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

endpackage

// File: rtl/pc_adder.sv
// Plain modulo-2^W adder; used for both PC+4 and PC+4+OFFSET.
module pc_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_update_unit.sv
// Program counter register with BOOT/RUN/STALL sequencing and a pending-target capture across stalls.
// Optional performance counters are enabled with `define PC_UPDATE_PERF_COUNTERS_EN.
module pc_update_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] OFFSET,
    input  logic              JUMP,
    input  logic              BRANCH,
    input  logic              ZERO,
    input  logic              BUSYWAIT,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_PLUS4,
    output logic [ADDR_W-1:0] TARGET,
    output logic              STALLED,
`ifdef PC_UPDATE_PERF_COUNTERS_EN
    output logic [31:0]       STALL_CYCLES,
    output logic [31:0]       TAKEN_COUNT,
`endif
    output logic [1:0]        DBG_STATE
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pend_tgt;
    logic              pend_valid;
    logic              stalled;
    logic [1:0]        state;
    logic              taken;

    pc_adder #(.W(ADDR_W)) u_add_step (
        .a   (pc),
        .b   (PC_STEP[ADDR_W-1:0]),
        .sum (pc_plus4)
    );

    pc_adder #(.W(ADDR_W)) u_add_target (
        .a   (pc_plus4),
        .b   (OFFSET),
        .sum (target)
    );

    assign taken = JUMP | (BRANCH & ZERO);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc         <= RESET_PC[ADDR_W-1:0];
            state      <= ST_BOOT;
            pend_valid <= 1'b0;
            pend_tgt   <= '0;
            stalled    <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    // Instruction inputs are meaningless before the first fetch.
                    if (!BUSYWAIT) begin
                        pc    <= pc_plus4;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (BUSYWAIT) begin
                        state      <= ST_STALL;
                        stalled    <= 1'b1;
                        pend_valid <= taken;
                        pend_tgt   <= target;
                    end else begin
                        pc <= taken ? target : pc_plus4;
                    end
                end
                ST_STALL: begin
                    if (!BUSYWAIT) begin
                        pc         <= pend_valid ? pend_tgt : pc_plus4;
                        pend_valid <= 1'b0;
                        stalled    <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                default: begin
                    state      <= ST_BOOT;
                    pend_valid <= 1'b0;
                    stalled    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_UPDATE_PERF_COUNTERS_EN
    logic [31:0] stall_cycles;
    logic [31:0] taken_count;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cycles <= '0;
            taken_count  <= '0;
        end else begin
            if (state == ST_STALL) stall_cycles <= stall_cycles + 32'd1;
            if ((state == ST_RUN && !BUSYWAIT && taken) ||
                (state == ST_STALL && !BUSYWAIT && pend_valid))
                taken_count <= taken_count + 32'd1;
        end
    end

    assign STALL_CYCLES = stall_cycles;
    assign TAKEN_COUNT  = taken_count;
`endif

    assign PC        = pc;
    assign PC_PLUS4  = pc_plus4;
    assign TARGET    = target;
    assign STALLED   = stalled;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: behavioural next-PC model checked every cycle plus literal pins.
module tb_pc_update_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    // clock / reset
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] OFFSET = '0;
    logic        JUMP = 1'b0;
    logic        BRANCH = 1'b0;
    logic        ZERO = 1'b0;
    logic        BUSYWAIT = 1'b0;
    logic [31:0] PC, PC_PLUS4, TARGET;
    logic        STALLED;
    logic [1:0]  DBG_STATE;
`ifdef PC_UPDATE_PERF_COUNTERS_EN
    logic [31:0] STALL_CYCLES, TAKEN_COUNT;
`endif

    always #5 CLK = ~CLK;

    pc_update_unit dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .OFFSET       (OFFSET),
        .JUMP         (JUMP),
        .BRANCH       (BRANCH),
        .ZERO         (ZERO),
        .BUSYWAIT     (BUSYWAIT),
        .PC           (PC),
        .PC_PLUS4     (PC_PLUS4),
        .TARGET       (TARGET),
        .STALLED      (STALLED),
`ifdef PC_UPDATE_PERF_COUNTERS_EN
        .STALL_CYCLES (STALL_CYCLES),
        .TAKEN_COUNT  (TAKEN_COUNT),
`endif
        .DBG_STATE    (DBG_STATE)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks whether the first fetch happened, whether a stall is open,
    // and what the stall remembered about the instruction that was blocked.
    logic [31:0] m_pc, m_ptgt, m_tgt;
    bit          m_booted, m_in_stall, m_pvalid, m_tk;
    logic [31:0] m_stall_cyc, m_taken_cnt;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_pc = RST_PC; m_booted = 0; m_in_stall = 0; m_pvalid = 0;
            m_ptgt = '0; m_stall_cyc = 0; m_taken_cnt = 0;
        end else begin
            m_tgt = m_pc + 32'd4 + OFFSET;
            m_tk  = JUMP || (BRANCH && ZERO);
            if (!m_booted) begin
                if (!BUSYWAIT) begin m_pc = m_pc + 32'd4; m_booted = 1; end
            end else if (m_in_stall) begin
                m_stall_cyc = m_stall_cyc + 1;
                if (!BUSYWAIT) begin
                    if (m_pvalid) begin m_pc = m_ptgt; m_taken_cnt = m_taken_cnt + 1; end
                    else m_pc = m_pc + 32'd4;
                    m_pvalid = 0; m_in_stall = 0;
                end
            end else if (BUSYWAIT) begin
                m_in_stall = 1; m_pvalid = m_tk; m_ptgt = m_tgt;
            end else begin
                if (m_tk) begin m_pc = m_tgt; m_taken_cnt = m_taken_cnt + 1; end
                else m_pc = m_pc + 32'd4;
            end
        end
    end

    // scoreboard compare on the inactive edge
    bit run_done = 0;
    always @(negedge CLK) begin
        if (!run_done) begin
            chk("pc_model", PC, m_pc);
            chk("pc_plus4_model", PC_PLUS4, m_pc + 32'd4);
            chk("target_model", TARGET, m_pc + 32'd4 + OFFSET);
            chk("stalled_model", {31'd0, STALLED}, {31'd0, m_in_stall});
`ifdef PC_UPDATE_PERF_COUNTERS_EN
            chk("stall_cycles_model", STALL_CYCLES, m_stall_cyc);
            chk("taken_count_model", TAKEN_COUNT, m_taken_cnt);
`endif
        end
    end

    // driver
    task automatic step(input bit j, input bit b, input bit z, input logic [31:0] off, input bit busy);
        JUMP = j; BRANCH = b; ZERO = z; OFFSET = off; BUSYWAIT = busy;
        @(posedge CLK); #1;
    endtask

    task automatic pin(input string name, input logic [31:0] exp_pc, input bit exp_st);
        chk({name, "_pc"}, PC, exp_pc);
        chk({name, "_stalled"}, {31'd0, STALLED}, {31'd0, exp_st});
    endtask

    initial begin
        // reset held
        repeat (3) @(posedge CLK);
        #1;
        pin("reset", RST_PC, 0);
        chk("reset_pc_plus4", PC_PLUS4, 32'h0);
`ifdef PC_UPDATE_PERF_COUNTERS_EN
        chk("reset_stall_cycles", STALL_CYCLES, 32'h0);
        chk("reset_taken_count", TAKEN_COUNT, 32'h0);
`endif
        RESET_N = 1;

        // sequential fetch
        step(0, 0, 0, 32'd0, 0); pin("boot", 32'd0, 0);
        step(0, 0, 0, 32'd0, 0); pin("seq4", 32'd4, 0);
        step(0, 0, 0, 32'd0, 0); pin("seq8", 32'd8, 0);

        // branch taken / not taken at PC=8
        step(0, 1, 1, 32'd12, 0); pin("beq_taken", 32'd24, 0);
        step(1, 0, 0, -32'sd20, 0); pin("jump_back", 32'd8, 0);
        step(0, 1, 0, 32'd12, 0); pin("beq_not_taken", 32'd12, 0);
        step(0, 0, 0, 32'd0, 0); pin("seq16", 32'd16, 0);
        step(1, 0, 0, -32'sd20, 0); pin("jump_neg", 32'd0, 0);

        // negative offset wrap at PC=0
        JUMP = 0; OFFSET = -32'sd8; #1;
        chk("target_wrap", TARGET, 32'hFFFF_FFFC);
        step(0, 0, 0, -32'sd8, 0); pin("seq_after_wrap", 32'd4, 0);

        // jump captured on first stall edge, inputs change during stall
        step(1, 0, 0, 32'd32, 1); pin("stall1", 32'd4, 1);
        step(0, 0, 0, 32'd0, 1);  pin("stall2", 32'd4, 1);
        step(0, 0, 0, 32'd0, 1);  pin("stall3", 32'd4, 1);
        step(0, 0, 0, 32'd0, 0);  pin("stall_release", 32'd40, 0);
`ifdef PC_UPDATE_PERF_COUNTERS_EN
        chk("stall_cycles_lit", STALL_CYCLES, 32'd3);
        chk("taken_count_lit", TAKEN_COUNT, 32'd4);
`endif

        // one-cycle stall, not taken
        step(1, 0, 0, -32'sd32, 0); pin("jump_to12", 32'd12, 0);
        step(0, 0, 0, 32'd0, 1);    pin("pulse_stall", 32'd12, 1);
        step(0, 0, 0, 32'd0, 0);    pin("pulse_release", 32'd16, 0);

        // back-to-back stalls with independent captures
        step(1, 0, 0, 32'd8, 1);    pin("b2b_stall_a", 32'd16, 1);
        step(0, 0, 0, 32'd0, 0);    pin("b2b_release_a", 32'd28, 0);
        step(0, 0, 0, 32'd64, 1);   pin("b2b_stall_b", 32'd28, 1);
        step(0, 0, 0, 32'd0, 0);    pin("b2b_release_b", 32'd32, 0);

        // reset mid-stall with pending taken target
        step(1, 0, 0, 32'd100, 1);  pin("pre_reset_stall", 32'd32, 1);
        #2 RESET_N = 0;
        #1;
        pin("async_reset", RST_PC, 0);
`ifdef PC_UPDATE_PERF_COUNTERS_EN
        chk("midreset_stall_cycles", STALL_CYCLES, 32'h0);
        chk("midreset_taken_count", TAKEN_COUNT, 32'h0);
`endif
        @(posedge CLK); #1;
        RESET_N = 1;
        step(1, 0, 0, 32'd100, 1);  pin("boot_hold", RST_PC, 0);
        step(1, 0, 0, 32'd100, 0);  pin("boot_after_reset", 32'd0, 0);
        step(0, 0, 0, 32'd0, 0);    pin("seq_after_reset", 32'd4, 0);

        // a few more model-checked cycles with mixed inputs
        step(0, 1, 1, 32'd16, 0);
        step(0, 0, 0, 32'd0, 1);
        step(0, 1, 1, 32'd4, 1);
        step(0, 0, 0, 32'd0, 0);
        step(1, 1, 1, 32'hFFFF_FFF0, 0);

        @(negedge CLK);
        run_done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
